fetch_pc_redirect_unit: RTL and testbench
=========================================

Name: fetch_pc_redirect_unit

Overview:
- Owns the program counter for the IF stage of the 5-stage pipeline.
- Consumes the sign-extended branch/JAL offset produced in ID, plus the branch decision, and redirects fetch to the target. Generates the IF/ID flush and a misaligned-target trap.
- Sits between the ID-stage offset generator / branch comparator and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect target.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard-unit stall. When 1, the PC holds and redirect inputs are ignored.
- Branch_taken  input  1  conditional branch in ID resolved taken.
- Is_jal  input  1  ID instruction is JAL.
- Is_jalr  input  1  ID instruction is JALR.
- Branch_offset  input  32  sign-extended B/J offset from ID.
- Jalr_imm  input  32  sign-extended I-type immediate for JALR.
- Jalr_base  input  32  forwarded rs1 value for JALR.
- PC_id  input  32  PC of the instruction currently in ID.
- PC_out  output  32  fetch address to instruction memory (registered).
- PC_plus4  output  32  PC_out + 4 (combinational), forwarded into IF/ID.
- Flush_ifid  output  1  kill the instruction entering IF/ID this edge (combinational).
- Redirect_valid  output  1  registered; high for one cycle after a redirect is taken.
- Misaligned_fault  output  1  registered; one-cycle pulse on a misaligned target.
- Redirect_count  output  CNT_W  saturating count of taken redirects.

Behaviour:
- Reset: asynchronous and active-high; it overrides everything at any time, including mid-redirect.
  - PC_out=RESET_PC, state=RUN, Redirect_valid=0, Misaligned_fault=0, Redirect_count=0.
  - Flush_ifid evaluates to 0 while reset is asserted.
- Target computation (mod 2^32, wrap silently, no overflow flag):
  - Branch/JAL: PC_id + Branch_offset.
  - JALR: (Jalr_base + Jalr_imm) with bit 0 cleared.
- Redirect request req = (Is_jalr | Is_jal | Branch_taken) & ~Stall & (state==RUN).
  - Source priority: Is_jalr > Is_jal > Branch_taken.
  - A simultaneous Branch_taken and Is_jal uses the JAL path; the result is identical since both use Branch_offset.
- Misaligned: req and target[1] == 1. Bit 0 is already clear for JALR; for B/J, bit 0 is always 0.
- FSM states RUN, BUBBLE, TRAP.
  - RUN, no req, Stall=0: PC_out <= PC_out+4.
  - RUN, Stall=1: PC_out holds, Flush_ifid=0, stay RUN.
  - RUN, req aligned: PC_out <= target, Flush_ifid=1 that cycle, Redirect_count++ (saturates at all-ones), next state BUBBLE.
  - RUN, req misaligned: PC_out <= TRAP_VECTOR, Flush_ifid=1, next state TRAP. Redirect_count is not incremented.
  - BUBBLE: Redirect_valid=1. ID holds the squashed bubble, so redirect inputs are ignored. PC_out <= PC_out+4 unless Stall. Next state RUN.
  - TRAP: Misaligned_fault=1 for exactly one cycle. Redirect inputs are ignored. PC_out <= PC_out+4 unless Stall. Next state RUN.
- Latency:
  - Redirect decided in cycle N; the target appears on PC_out in cycle N+1.
  - Exactly one wrong-path instruction is squashed, via Flush_ifid in cycle N.
- Stall in BUBBLE/TRAP holds PC_out, but the state still advances to RUN. The flag pulses stay one cycle wide.
- Back-to-back redirects: the second request cannot be taken in BUBBLE/TRAP, by construction of req. Each pulse is therefore at most one cycle wide.
- PC_out+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.

Test Plan:
- Reset, then 3 free-running cycles -> PC_out 0x0, 0x4, 0x8, 0xC; Flush_ifid=0; Redirect_count=0.
- PC_id=0x20, Branch_taken=1, Branch_offset=0xFFFF_FFF0 -> Flush_ifid=1 same cycle; next PC_out=0x10; Redirect_valid=1 one cycle; Redirect_count=1.
- Is_jalr=1, Jalr_base=0x1003, Jalr_imm=0x4 -> next PC_out=0x1006? No: bit 0 cleared gives 0x1006 with bit 1 set -> Misaligned_fault pulses one cycle later; PC_out=0x100; count unchanged.
- Is_jal=1 and Stall=1 together -> no redirect, PC_out holds, Flush_ifid=0. Stall drops with Is_jal still high -> redirect to PC_id+offset.
- Branch_taken held high 2 cycles, PC_id=0x40, offset=0x8 -> exactly one redirect to 0x48; next cycle 0x4C; count=1.
- Reset asserted during BUBBLE, mid-cycle (asynchronously) -> PC_out=RESET_PC immediately, Redirect_valid=0. Separately, force count to all-ones, then redirect -> count stays all-ones.

Source files
------------

// File: rtl/fetch_pc_redirect_unit.sv
// fetch_pc_redirect_unit
//   Owns the IF-stage program counter. Redirects fetch to branch, JAL or JALR
//   targets resolved in ID. Squashes the wrong-path fetch through Flush_ifid.
//   A target with bit 1 set sends fetch to TRAP_VECTOR instead.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   Stall             hazard stall; holds PC and ignores redirect inputs
//   Branch_taken      conditional branch in ID resolved taken
//   Is_jal, Is_jalr   ID instruction is JAL / JALR
//   Branch_offset     sign-extended B/J offset
//   Jalr_imm          sign-extended I-type immediate for JALR
//   Jalr_base         forwarded rs1 value for JALR
//   PC_id             PC of the instruction in ID
//   PC_out            registered fetch address
//   PC_plus4          PC_out + 4 (combinational)
//   Flush_ifid        kill the IF/ID entry this edge (combinational)
//   Redirect_valid    one-cycle pulse after a taken redirect (registered)
//   Misaligned_fault  one-cycle pulse after a misaligned target (registered)
//   Redirect_count    saturating count of taken aligned redirects
module fetch_pc_redirect_unit #(
   parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
   parameter logic [31:0]  TRAP_VECTOR = 32'h0000_0100,
   parameter int unsigned  CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             Branch_taken,
   input  logic             Is_jal,
   input  logic             Is_jalr,
   input  logic [31:0]      Branch_offset,
   input  logic [31:0]      Jalr_imm,
   input  logic [31:0]      Jalr_base,
   input  logic [31:0]      PC_id,
   output logic [31:0]      PC_out,
   output logic [31:0]      PC_plus4,
   output logic             Flush_ifid,
   output logic             Redirect_valid,
   output logic             Misaligned_fault,
   output logic [CNT_W-1:0] Redirect_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      TRAP   = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [31:0]      pc_d;
   logic             rv_d;
   logic             mf_d;
   logic [CNT_W-1:0] cnt_d;
   logic [31:0]      br_target;
   logic [31:0]      jalr_target;
   logic [31:0]      target;
   logic             req;

   // Target selection: JALR has priority; branch and JAL share one adder.
   always_comb begin
      br_target   = PC_id + Branch_offset;
      jalr_target = (Jalr_base + Jalr_imm) & ~32'h0000_0001;
      target      = Is_jalr ? jalr_target : br_target;
      req         = (Is_jalr | Is_jal | Branch_taken) & ~Stall & (state == RUN);
   end

   assign PC_plus4   = PC_out + 32'd4;
   assign Flush_ifid = req & ~reset;

   // Next-state, next-PC and pulse generation.
   always_comb begin
      state_d = state;
      pc_d    = PC_out;
      rv_d    = 1'b0;
      mf_d    = 1'b0;
      cnt_d   = Redirect_count;
      case (state)
         RUN: begin
            if (req) begin
               if (target[1]) begin
                  pc_d    = TRAP_VECTOR;
                  mf_d    = 1'b1;
                  state_d = TRAP;
               end else begin
                  pc_d    = target;
                  rv_d    = 1'b1;
                  state_d = BUBBLE;
                  if (Redirect_count != {CNT_W{1'b1}}) begin
                     cnt_d = Redirect_count + CNT_W'(1);
                  end
               end
            end else if (!Stall) begin
               pc_d = PC_plus4;
            end
         end
         BUBBLE, TRAP: begin
            // Redirect inputs refer to the squashed slot; state advances even under stall.
            if (!Stall) begin
               pc_d = PC_plus4;
            end
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= RUN;
         PC_out           <= RESET_PC;
         Redirect_valid   <= 1'b0;
         Misaligned_fault <= 1'b0;
         Redirect_count   <= '0;
      end else begin
         state            <= state_d;
         PC_out           <= pc_d;
         Redirect_valid   <= rv_d;
         Misaligned_fault <= mf_d;
         Redirect_count   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_redirect_unit.sv
module tb_fetch_pc_redirect_unit;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             Stall;
   logic             Branch_taken;
   logic             Is_jal;
   logic             Is_jalr;
   logic [31:0]      Branch_offset;
   logic [31:0]      Jalr_imm;
   logic [31:0]      Jalr_base;
   logic [31:0]      PC_id;
   logic [31:0]      PC_out;
   logic [31:0]      PC_plus4;
   logic             Flush_ifid;
   logic             Redirect_valid;
   logic             Misaligned_fault;
   logic [CNT_W-1:0] Redirect_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt;

   fetch_pc_redirect_unit #(
      .RESET_PC    (32'h0000_0000),
      .TRAP_VECTOR (32'h0000_0100),
      .CNT_W       (CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .Stall            (Stall),
      .Branch_taken     (Branch_taken),
      .Is_jal           (Is_jal),
      .Is_jalr          (Is_jalr),
      .Branch_offset    (Branch_offset),
      .Jalr_imm         (Jalr_imm),
      .Jalr_base        (Jalr_base),
      .PC_id            (PC_id),
      .PC_out           (PC_out),
      .PC_plus4         (PC_plus4),
      .Flush_ifid       (Flush_ifid),
      .Redirect_valid   (Redirect_valid),
      .Misaligned_fault (Misaligned_fault),
      .Redirect_count   (Redirect_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Stall = 0; Branch_taken = 0; Is_jal = 0; Is_jalr = 0;
      Branch_offset = 0; Jalr_imm = 0; Jalr_base = 0; PC_id = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step();
      step();
      check("rst_pc", PC_out, 32'h0);
      check("rst_flush", 32'(Flush_ifid), 32'h0);
      check("rst_cnt", 32'(Redirect_count), 32'h0);
      check("rst_rv", 32'(Redirect_valid), 32'h0);
      check("rst_mf", 32'(Misaligned_fault), 32'h0);
      reset = 0;
      #1;
      check("run_pc0", PC_out, 32'h0);
      check("run_plus4", PC_plus4, 32'h4);
      step(); check("run_pc4", PC_out, 32'h4);
      step(); check("run_pc8", PC_out, 32'h8);
      step(); check("run_pcC", PC_out, 32'hC);
      check("run_flush", 32'(Flush_ifid), 32'h0);
      check("run_cnt", 32'(Redirect_count), 32'h0);

      // Backward branch: 0x20 + (-16) = 0x10
      PC_id = 32'h20; Branch_offset = 32'hFFFF_FFF0; Branch_taken = 1;
      #1;
      check("br_flush", 32'(Flush_ifid), 32'h1);
      step();
      idle_inputs();
      #1;
      check("br_pc", PC_out, 32'h10);
      check("br_rv", 32'(Redirect_valid), 32'h1);
      check("br_cnt", 32'(Redirect_count), 32'h1);
      check("br_bubble_flush", 32'(Flush_ifid), 32'h0);
      step();
      check("br_pc_next", PC_out, 32'h14);
      check("br_rv_drop", 32'(Redirect_valid), 32'h0);

      // JALR 0x1003+4 = 0x1007 -> 0x1006, bit 1 set -> trap
      Is_jalr = 1; Jalr_base = 32'h1003; Jalr_imm = 32'h4;
      #1;
      check("jalr_flush", 32'(Flush_ifid), 32'h1);
      step();
      idle_inputs();
      #1;
      check("jalr_pc_trap", PC_out, 32'h100);
      check("jalr_mf", 32'(Misaligned_fault), 32'h1);
      check("jalr_rv", 32'(Redirect_valid), 32'h0);
      check("jalr_cnt", 32'(Redirect_count), 32'h1);
      step();
      check("jalr_pc_next", PC_out, 32'h104);
      check("jalr_mf_drop", 32'(Misaligned_fault), 32'h0);

      // JAL under stall, then stall drops: 0x60 + 0x20 = 0x80
      PC_id = 32'h60; Branch_offset = 32'h20; Is_jal = 1; Stall = 1;
      #1;
      check("jal_stall_flush", 32'(Flush_ifid), 32'h0);
      step();
      check("jal_stall_pc", PC_out, 32'h104);
      check("jal_stall_cnt", 32'(Redirect_count), 32'h1);
      Stall = 0;
      #1;
      check("jal_flush", 32'(Flush_ifid), 32'h1);
      step();
      idle_inputs();
      #1;
      check("jal_pc", PC_out, 32'h80);
      check("jal_cnt", 32'(Redirect_count), 32'h2);
      step();
      check("jal_pc_next", PC_out, 32'h84);

      // Branch held two cycles: only one redirect to 0x48
      PC_id = 32'h40; Branch_offset = 32'h8; Branch_taken = 1;
      step();
      check("hold_pc", PC_out, 32'h48);
      check("hold_bubble_flush", 32'(Flush_ifid), 32'h0);
      step();
      Branch_taken = 0;
      #1;
      check("hold_pc_next", PC_out, 32'h4C);
      check("hold_cnt", 32'(Redirect_count), 32'h3);

      // Stall during BUBBLE holds PC but pulse stays one cycle
      PC_id = 32'h200; Branch_offset = 32'h0; Branch_taken = 1;
      step();
      idle_inputs();
      Stall = 1;
      #1;
      check("bstall_pc", PC_out, 32'h200);
      check("bstall_rv", 32'(Redirect_valid), 32'h1);
      step();
      check("bstall_pc_hold", PC_out, 32'h200);
      check("bstall_rv_drop", 32'(Redirect_valid), 32'h0);
      Stall = 0;
      step();
      check("bstall_pc_next", PC_out, 32'h204);

      // Asynchronous reset in the middle of a BUBBLE cycle
      PC_id = 32'h300; Branch_taken = 1;
      step();
      check("areset_pre_pc", PC_out, 32'h300);
      check("areset_pre_rv", 32'(Redirect_valid), 32'h1);
      #2;
      reset = 1;
      #1;
      check("areset_pc", PC_out, 32'h0);
      check("areset_rv", 32'(Redirect_valid), 32'h0);
      check("areset_cnt", 32'(Redirect_count), 32'h0);
      check("areset_flush", 32'(Flush_ifid), 32'h0);
      step();
      idle_inputs();
      reset = 0;
      #1;

      // PC increment wraps at the top of the address space
      PC_id = 32'hFFFF_FFF8; Branch_offset = 32'h4; Branch_taken = 1;
      step();
      idle_inputs();
      #1;
      check("wrap_pc", PC_out, 32'hFFFF_FFFC);
      check("wrap_plus4", PC_plus4, 32'h0);
      step();
      check("wrap_pc_next", PC_out, 32'h0);
      exp_cnt = 1;

      // Counter saturates at all-ones
      for (int i = 0; i < 16; i++) begin
         PC_id = 32'h1000; Branch_taken = 1;
         step();
         Branch_taken = 0;
         step();
         if (exp_cnt < 15) exp_cnt++;
      end
      check("sat_cnt", 32'(Redirect_count), 32'(exp_cnt));
      check("sat_cnt_ones", 32'(Redirect_count), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
